// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD / 7-segment display converter.
// Holds the active-low segment table, the blank pattern and the FSM state encoding.
package bcd_pkg;

    // Active-low {a,b,c,d,e,f,g} patterns for digits 0..9
    localparam logic [6:0] SEG_CODE [0:9] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
        7'h24, 7'h20, 7'h0F, 7'h00, 7'h04
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/bcd_seg_encode.sv
// Single-digit BCD to active-low 7-segment encoder.
// Ports: digit_i (BCD digit), blank_i (force all segments off), seg_o ({a..g}, 0 = lit).
module bcd_seg_encode
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Non-BCD codes fall through to the blank pattern
    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            for (int i = 0; i < 10; i++) begin
                if (digit_i == 4'(i)) seg_o = SEG_CODE[i];
            end
        end
    end

endmodule

// File: rtl/bcd_seg_converter.sv
// Sequential binary to packed-BCD and 7-segment converter (double-dabble, one bit/clock).
// Ports: clk, rst (sync, active-high), start/bin/blank_lz in; busy, done, bcd, seg, overflow out.
module bcd_seg_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  overflow
);

    localparam int AW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   sr_q;
    logic [AW-1:0]      acc_q;
    logic [CW-1:0]      cnt_q;
    logic               ovf_q;
    logic               blz_q;
    logic [AW-1:0]      bcd_q;
    logic [7*DIGITS-1:0] seg_q;
    logic               ovf_out_q;
    logic               done_q;

    logic [AW-1:0]      acc_corr;
    logic [AW-1:0]      acc_shift;
    logic               ovf_bit;
    logic               last;
    logic [DIGITS:0]    zero_from;
    logic [DIGITS-1:0]  blank;
    logic [7*DIGITS-1:0] seg_enc;

    // Add-3 correction on every digit that would reach 10 after the shift
    for (genvar k = 0; k < DIGITS; k++) begin : g_corr
        assign acc_corr[4*k +: 4] = (acc_q[4*k +: 4] >= 4'd5)
                                  ? acc_q[4*k +: 4] + 4'd3
                                  : acc_q[4*k +: 4];
    end

    assign acc_shift = {acc_corr[AW-2:0], sr_q[BIN_W-1]};
    // A 1 leaving the top digit means the value needs one more digit
    assign ovf_bit   = acc_corr[AW-1];
    assign last      = (cnt_q == LAST);

    // zero_from[k]: digits k..DIGITS-1 of the final result are all zero
    assign zero_from[DIGITS] = 1'b1;
    for (genvar k = 0; k < DIGITS; k++) begin : g_enc
        assign zero_from[k] = (acc_shift[4*k +: 4] == 4'd0) && zero_from[k+1];
        assign blank[k]     = blz_q && (k != 0) && zero_from[k];

        bcd_seg_encode u_enc (
            .digit_i (acc_shift[4*k +: 4]),
            .blank_i (blank[k]),
            .seg_o   (seg_enc[7*k +: 7])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            blz_q     <= 1'b0;
            bcd_q     <= '0;
            seg_q     <= '1;
            ovf_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    sr_q  <= bin;
                    acc_q <= '0;
                    cnt_q <= '0;
                    ovf_q <= 1'b0;
                    blz_q <= blank_lz;
                end
            end else begin
                acc_q <= acc_shift;
                sr_q  <= sr_q << 1;
                ovf_q <= ovf_q | ovf_bit;
                cnt_q <= cnt_q + CW'(1);
                if (last) begin
                    bcd_q     <= acc_shift;
                    seg_q     <= seg_enc;
                    ovf_out_q <= ovf_q | ovf_bit;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign done     = done_q;
    assign bcd      = bcd_q;
    assign seg      = seg_q;
    assign overflow = ovf_out_q;

endmodule

// File: doc/bcd_seg_converter.md
# bcd_seg_converter

Sequential binary-to-decimal display converter: accepts an unsigned BIN_W-bit value on a start strobe and produces DIGITS packed BCD digits plus active-low 7-segment patterns. It uses the iterative shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It adds three things to the existing fixed 8-bit, 3-digit combinational decoders: width and digit count are parameters, overflow is detected, and leading-zero blanking is optional. It sits between the datapath result registers and the board's segment displays.

## Interface
- BIN_W, 8, input width in bits; legal range 1..32
- DIGITS, 3, number of decimal digits produced; legal range 1..10
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a conversion; accepted only while busy=0
- bin  in  BIN_W  value to convert; sampled on the accepting edge
- blank_lz  in  1  leading-zero blanking enable; sampled with bin
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse; new results are valid from this cycle on
- bcd  out  4*DIGITS  packed BCD; digit k is at [4k+3:4k], digit 0 is the units digit
- seg  out  7*DIGITS  digit k is at [7k+6:7k], ordered {a,b,c,d,e,f,g}; active-low, so 0 means lit
- overflow  out  1  the value does not fit in DIGITS digits

## Operation
- The FSM has two states, IDLE and SHIFT.
- IDLE, on start=1: latch bin into the shift register, clear the BCD accumulator, clear the bit counter and the overflow flag, latch blank_lz, then go to SHIFT.
- SHIFT, each cycle, in this order:
  - add 3 to every accumulator digit that is ≥5;
  - shift {accumulator, shift register} left by one;
  - if the bit shifted out of the top digit is 1, set the sticky overflow flag;
  - increment the counter.
- After the BIN_W-th shift: load bcd, seg and overflow from the accumulator and flag, pulse done, return to IDLE.
- bcd, seg and overflow hold their previous values for the whole conversion and change only on the done edge.
- On overflow, bcd holds value mod 10^DIGITS and seg shows those digits.
- Segment codes, 0–9 (hex, active-low): 01, 4F, 12, 06, 4C, 24, 20, 0F, 00, 04.
- Leading-zero blanking (latched blank_lz=1): every digit above the most-significant nonzero digit gets seg = 7F. Digit 0 is never blanked, so a value of 0 shows a single "0". bcd is never blanked.
- start while busy=1 is ignored; no queueing.
- rst=1 at any edge, including mid-conversion, forces the reset state and the in-flight conversion is discarded.

## Timing
- Reset values:
  - busy=0, done=0, overflow=0
  - bcd=0
  - seg all ones (every digit blank); state IDLE
- The edge that accepts start is E0.
- busy=1 from E0 through E(BIN_W).
- done=1 and the new results appear after edge E(BIN_W), so latency is exactly BIN_W cycles from the accepting edge.
- done is high for exactly one cycle; in that cycle busy=0. A start asserted in the done cycle is accepted, so back-to-back conversions run with no idle cycle.
- rst and start asserted together: rst wins.

## Structure
- Shared package bcd_pkg holds:
  - the segment constant array SEG_CODE[0:9] (active-low {a..g});
  - SEG_BLANK = 7'h7F;
  - the state encoding (IDLE, SHIFT).
- Sub-module bcd_seg_encode (combinational): 4-bit digit plus blank flag in, 7-bit segment pattern out. It is instantiated DIGITS times by a generate loop.
- The add-3 correction is a per-digit generate loop inside the top module.
- The counter width is clog2(BIN_W+1).

## Test plan
- BIN_W=8, DIGITS=3, bin=198, blank_lz=0:
  - done is high 8 cycles after start;
  - bcd=12'h198, overflow=0;
  - seg = {4F, 04, 00} (digits 2, 1, 0);
  - busy high for the 8 cycles before done.
- bin=255 → bcd=12'h255. bin=0 with blank_lz=1 → bcd=0, seg digits 2 and 1 = 7F, digit 0 = 01.
- BIN_W=8, DIGITS=2, bin=198 → overflow=1, bcd=8'h98. A following conversion of bin=42 → overflow=0, bcd=8'h42.
- Start pulsed again with bin=7 during a conversion of 123:
  - the second start is ignored;
  - the result is 12'h123 with a single done pulse.
- rst asserted at cycle 4 of a conversion:
  - the next cycle shows reset values;
  - no done pulse follows;
  - a fresh start of 99 gives 12'h099 after 8 cycles.
- BIN_W=16, DIGITS=5, bin=65535, with start re-asserted in the done cycle of a prior conversion:
  - the back-to-back start is accepted;
  - bcd=20'h65535 after 16 cycles.
